// File: rtl/rv_seq_core.sv
// rv_seq_core: minimal multi-cycle RV32 subset core (LUI, AUIPC, ADDI, SW, JAL)
// with a fetch handshake, a memory-mapped UART byte port and an optional
// cycle budget. Unsupported encodings stop the core with a sticky flag.
module rv_seq_core #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          NREGS      = 32,
  parameter logic [31:0] UART_ADDR  = 32'h1000_0000,
  parameter int          MAX_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic        io_valid,
  output logic [7:0]  io_data,
  input  logic        io_ready,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] cycle_count
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    IOWAIT = 2'd2,
    HALT   = 2'd3
  } state_e;

  localparam int          IW        = $clog2(NREGS);
  localparam logic [5:0]  NREGS_W   = 6'(NREGS);
  localparam logic [31:0] MAX_CYC_W = 32'(MAX_CYCLES);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_e      state_r, next_state_s;
  logic [31:0] pc_r, next_pc_s;
  logic [31:0] instr_r;
  logic [31:0] regs_r [NREGS];
  logic        imem_req_r, io_valid_r, halted_r, illegal_r;
  logic [7:0]  io_data_r;
  logic [31:0] cycle_count_r;

  // instruction fields and immediates
  logic [6:0]  opcode_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [2:0]  funct3_s;
  logic [31:0] imm_i_s, imm_s_s, imm_u_s, imm_j_s;
  logic        rd_bad_s, rs1_bad_s, rs2_bad_s;
  logic [31:0] rs1_val_s, rs2_val_s;

  // execute-stage decode results
  logic        exec_bad_s, exec_wen_s, exec_jump_s, exec_store_s, uart_hit_s;
  logic [31:0] exec_wdata_s, sw_addr_s;

  // FSM side effects
  logic        instr_load_s, reg_we_s, illegal_set_s, io_load_s, budget_hit_s;

  assign opcode_s  = instr_r[6:0];
  assign rd_s      = instr_r[11:7];
  assign funct3_s  = instr_r[14:12];
  assign rs1_s     = instr_r[19:15];
  assign rs2_s     = instr_r[24:20];
  assign imm_i_s   = {{20{instr_r[31]}}, instr_r[31:20]};
  assign imm_s_s   = {{20{instr_r[31]}}, instr_r[31:25], instr_r[11:7]};
  assign imm_u_s   = {instr_r[31:12], 12'h000};
  assign imm_j_s   = {{11{instr_r[31]}}, instr_r[31], instr_r[19:12], instr_r[20],
                      instr_r[30:21], 1'b0};
  assign rd_bad_s  = ({1'b0, rd_s}  >= NREGS_W);
  assign rs1_bad_s = ({1'b0, rs1_s} >= NREGS_W);
  assign rs2_bad_s = ({1'b0, rs2_s} >= NREGS_W);
  assign sw_addr_s = rs1_val_s + imm_s_s;
  assign uart_hit_s = exec_store_s && (sw_addr_s == UART_ADDR);
  assign budget_hit_s = (MAX_CYC_W != 32'd0) && (cycle_count_r >= MAX_CYC_W);

  // register file read ports; x0 and out-of-range indices read as zero
  always_comb begin
    rs1_val_s = 32'h0;
    rs2_val_s = 32'h0;
    if ((rs1_s != 5'd0) && !rs1_bad_s) begin
      rs1_val_s = regs_r[rs1_s[IW-1:0]];
    end else begin
      rs1_val_s = 32'h0;
    end
    if ((rs2_s != 5'd0) && !rs2_bad_s) begin
      rs2_val_s = regs_r[rs2_s[IW-1:0]];
    end else begin
      rs2_val_s = 32'h0;
    end
  end

  // decode the latched instruction into write-back / control decisions
  always_comb begin
    exec_bad_s   = 1'b0;
    exec_wen_s   = 1'b0;
    exec_jump_s  = 1'b0;
    exec_store_s = 1'b0;
    exec_wdata_s = 32'h0;
    case (opcode_s)
      OP_LUI: begin
        exec_bad_s   = rd_bad_s;
        exec_wen_s   = 1'b1;
        exec_wdata_s = imm_u_s;
      end
      OP_AUIPC: begin
        exec_bad_s   = rd_bad_s;
        exec_wen_s   = 1'b1;
        exec_wdata_s = pc_r + imm_u_s;
      end
      OP_ADDI: begin
        exec_bad_s   = (funct3_s != 3'b000) || rd_bad_s || rs1_bad_s;
        exec_wen_s   = 1'b1;
        exec_wdata_s = rs1_val_s + imm_i_s;
      end
      OP_JAL: begin
        exec_bad_s   = rd_bad_s;
        exec_wen_s   = 1'b1;
        exec_jump_s  = 1'b1;
        exec_wdata_s = pc_r + 32'd4;
      end
      OP_SW: begin
        exec_bad_s   = (funct3_s != 3'b010) || rs1_bad_s || rs2_bad_s;
        exec_store_s = 1'b1;
      end
      default: begin
        exec_bad_s = 1'b1;
      end
    endcase
  end

  // next-state and side-effect logic of the sequencer
  always_comb begin
    next_state_s  = state_r;
    next_pc_s     = pc_r;
    instr_load_s  = 1'b0;
    reg_we_s      = 1'b0;
    illegal_set_s = 1'b0;
    io_load_s     = 1'b0;
    case (state_r)
      FETCH: begin
        // imem_req_r gates acceptance so the reset cycle never consumes a word
        if (imem_req_r && imem_valid) begin
          instr_load_s = 1'b1;
          next_state_s = EXEC;
        end else begin
          next_state_s = FETCH;
        end
      end
      EXEC: begin
        if (exec_bad_s) begin
          illegal_set_s = 1'b1;
          next_state_s  = HALT;
        end else if (uart_hit_s) begin
          // PC advances only once the byte has been taken
          io_load_s    = 1'b1;
          next_state_s = IOWAIT;
        end else begin
          reg_we_s     = exec_wen_s && (rd_s != 5'd0);
          next_pc_s    = exec_jump_s ? (pc_r + imm_j_s) : (pc_r + 32'd4);
          next_state_s = budget_hit_s ? HALT : FETCH;
        end
      end
      IOWAIT: begin
        if (io_ready) begin
          next_pc_s    = pc_r + 32'd4;
          next_state_s = budget_hit_s ? HALT : FETCH;
        end else begin
          next_state_s = IOWAIT;
        end
      end
      HALT: begin
        next_state_s = HALT;
      end
      default: begin
        next_state_s = HALT;
      end
    endcase
  end

  // sequencer state, PC and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= FETCH;
      pc_r          <= RESET_PC;
      instr_r       <= 32'h0;
      imem_req_r    <= 1'b0;
      io_valid_r    <= 1'b0;
      io_data_r     <= 8'h00;
      halted_r      <= 1'b0;
      illegal_r     <= 1'b0;
      cycle_count_r <= 32'h0;
    end else begin
      state_r       <= next_state_s;
      pc_r          <= next_pc_s;
      if (instr_load_s) begin
        instr_r <= imem_rdata;
      end
      imem_req_r    <= (next_state_s == FETCH);
      io_valid_r    <= (next_state_s == IOWAIT);
      if (io_load_s) begin
        io_data_r <= rs2_val_s[7:0];
      end
      halted_r      <= (next_state_s == HALT);
      illegal_r     <= illegal_r | illegal_set_s;
      cycle_count_r <= cycle_count_r + 32'd1;
    end
  end

  // architectural register file write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= 32'h0;
      end
    end else if (reg_we_s) begin
      regs_r[rd_s[IW-1:0]] <= exec_wdata_s;
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_r;
  assign io_valid    = io_valid_r;
  assign io_data     = io_data_r;
  assign halted      = halted_r;
  assign illegal     = illegal_r;
  assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_rv_seq_core.sv
// tb_rv_seq_core: scenario tasks with a UART byte scoreboard, a variable-latency
// instruction memory and a second instance configured with a cycle budget.
module tb_rv_seq_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (16 registers, unlimited budget)
  logic        rst_n = 1'b0;
  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic        io_valid, io_ready, halted, illegal;
  logic [7:0]  io_data;
  logic [31:0] cycle_count;

  // budget instance (32 registers, 20-cycle budget), fed a JAL x0,0 loop
  logic        b_rst_n = 1'b0;
  logic        b_imem_req, b_io_valid, b_halted, b_illegal;
  logic [31:0] b_imem_addr, b_cycle_count;
  logic [7:0]  b_io_data;
  logic        b_io_ready = 1'b0;
  logic [31:0] b_imem_rdata = 32'h0000006F;
  logic        b_imem_valid;
  assign b_imem_valid = b_imem_req;

  rv_seq_core #(.RESET_PC(32'h0), .NREGS(16), .UART_ADDR(32'h1000_0000), .MAX_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .io_valid(io_valid),
    .io_data(io_data), .io_ready(io_ready), .halted(halted), .illegal(illegal),
    .cycle_count(cycle_count));

  rv_seq_core #(.RESET_PC(32'h0), .NREGS(32), .UART_ADDR(32'h1000_0000), .MAX_CYCLES(20)) dut_bud (
    .clk(clk), .rst_n(b_rst_n), .imem_req(b_imem_req), .imem_addr(b_imem_addr),
    .imem_rdata(b_imem_rdata), .imem_valid(b_imem_valid), .io_valid(b_io_valid),
    .io_data(b_io_data), .io_ready(b_io_ready), .halted(b_halted), .illegal(b_illegal),
    .cycle_count(b_cycle_count));

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mem [64];
  int          fetch_delay = 0;
  int          ready_hold = 0;
  logic [7:0]  exp_q [$];
  int          xfer_count = 0;
  int          valid_len = 0;

  // instruction memory: answers each fetch after fetch_delay cycles
  initial begin
    int          wait_cnt;
    logic [31:0] req_addr;
    wait_cnt = 0;
    req_addr = 32'h0;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req) begin
        if (wait_cnt == 0) begin
          req_addr = imem_addr;
        end else begin
          vectors++;
          if (imem_addr !== req_addr) begin
            $display("FAIL fetch_addr_stable: imem_addr=%h required %h", imem_addr, req_addr);
            miscompares++;
          end
        end
        if (wait_cnt >= fetch_delay) begin
          imem_valid = 1'b1;
          imem_rdata = mem[imem_addr[7:2]];
          wait_cnt   = 0;
        end else begin
          imem_valid = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_valid = 1'b0;
        wait_cnt   = 0;
      end
    end
  end

  // UART sink: holds io_ready low for ready_hold cycles, scoreboards each byte
  initial begin
    int         run;
    logic [7:0] first;
    logic [7:0] exp_b;
    run = 0;
    first = 8'h00;
    io_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && io_valid) begin
        run++;
        if (run == 1) begin
          first = io_data;
        end else begin
          vectors++;
          if (io_data !== first) begin
            $display("FAIL io_data_stable: io_data=%h required %h", io_data, first);
            miscompares++;
          end
        end
        if (run > ready_hold) begin
          io_ready = 1'b1;
          xfer_count++;
          valid_len = run;
          vectors++;
          if (exp_q.size() == 0) begin
            $display("FAIL io_byte: unexpected byte %h, none required", io_data);
            miscompares++;
          end else begin
            exp_b = exp_q.pop_front();
            if (io_data !== exp_b) begin
              $display("FAIL io_byte: io_data=%h required %h", io_data, exp_b);
              miscompares++;
            end
          end
        end else begin
          io_ready = 1'b0;
        end
      end else begin
        io_ready = 1'b0;
        run = 0;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h00000013;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_uart_prog();
    clear_mem();
    mem[0] = 32'h100000B7;  // LUI  x1, 0x10000
    mem[1] = 32'h04100113;  // ADDI x2, x0, 0x41
    mem[2] = 32'h0020A023;  // SW   x2, 0(x1)
  endtask

  task automatic wait_xfers(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (xfer_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (xfer_count < target) begin
      $display("FAIL %s: transfers=%0d required %0d", name, xfer_count, target);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    vectors += 7;
    if (imem_req !== 1'b0) begin $display("FAIL rst_imem_req: got %b required 0", imem_req); miscompares++; end
    if (io_valid !== 1'b0) begin $display("FAIL rst_io_valid: got %b required 0", io_valid); miscompares++; end
    if (io_data !== 8'h00) begin $display("FAIL rst_io_data: got %h required 00", io_data); miscompares++; end
    if (halted !== 1'b0) begin $display("FAIL rst_halted: got %b required 0", halted); miscompares++; end
    if (illegal !== 1'b0) begin $display("FAIL rst_illegal: got %b required 0", illegal); miscompares++; end
    if (cycle_count !== 32'h0) begin $display("FAIL rst_cycle_count: got %0d required 0", cycle_count); miscompares++; end
    if (imem_addr !== 32'h0) begin $display("FAIL rst_pc: got %h required 0", imem_addr); miscompares++; end
    clear_mem();
    fetch_delay = 5;
    rst_n = 1'b1;
    @(negedge clk);
    vectors += 3;
    if (imem_req !== 1'b1) begin $display("FAIL first_req: got %b required 1", imem_req); miscompares++; end
    if (imem_addr !== 32'h0) begin $display("FAIL first_addr: got %h required 0", imem_addr); miscompares++; end
    if (cycle_count !== 32'd1) begin $display("FAIL first_count: got %0d required 1", cycle_count); miscompares++; end
  endtask

  task automatic test_uart(input int hold, input int delay, input string tag);
    int base;
    int n;
    load_uart_prog();
    fetch_delay = delay;
    ready_hold  = hold;
    exp_q.delete();
    exp_q.push_back(8'h41);
    base = xfer_count;
    apply_reset();
    wait_xfers(base + 1, 300, {tag, "_xfer"});
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors += 2;
    if (imem_addr !== 32'hC) begin $display("FAIL %s_pc: got %h required 0000000c", tag, imem_addr); miscompares++; end
    if (valid_len !== hold + 1) begin $display("FAIL %s_valid_len: got %0d required %0d", tag, valid_len, hold + 1); miscompares++; end
    repeat (30) @(negedge clk);
    vectors++;
    if (xfer_count !== base + 1) begin $display("FAIL %s_one_pulse: transfers=%0d required %0d", tag, xfer_count - base, 1); miscompares++; end
  endtask

  task automatic test_program();
    int base;
    clear_mem();
    mem[0]  = 32'h10000197;  // AUIPC x3, 0x10000      x3 = 0x10000000
    mem[1]  = 32'hFFF00213;  // ADDI  x4, x0, -1       x4 = 0xFFFFFFFF
    mem[2]  = 32'h04320213;  // ADDI  x4, x4, 0x43     x4 = 0x42 (wraps)
    mem[3]  = 32'h008002EF;  // JAL   x5, +8           x5 = 0x10, pc = 0x14
    mem[4]  = 32'h0041A023;  // SW    x4, 0(x3)        skipped by the jump
    mem[5]  = 32'h0041A023;  // SW    x4, 0(x3)        -> 0x42
    mem[6]  = 32'h0051A023;  // SW    x5, 0(x3)        -> 0x10
    mem[7]  = 32'h0041A223;  // SW    x4, 4(x3)        not the UART, dropped
    mem[8]  = 32'h01018313;  // ADDI  x6, x3, 0x10
    mem[9]  = 32'hFE432823;  // SW    x4, -16(x6)      -> 0x42
    mem[10] = 32'h05500013;  // ADDI  x0, x0, 0x55     ignored
    mem[11] = 32'h0001A023;  // SW    x0, 0(x3)        -> 0x00
    mem[12] = 32'h0000006F;  // JAL   x0, 0            park at 0x30
    fetch_delay = 1;
    ready_hold  = 2;
    exp_q.delete();
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h00);
    base = xfer_count;
    apply_reset();
    wait_xfers(base + 4, 800, "prog_xfer");
    repeat (40) @(negedge clk);
    vectors += 3;
    if (imem_addr !== 32'h30) begin $display("FAIL prog_pc: got %h required 00000030", imem_addr); miscompares++; end
    if (xfer_count !== base + 4) begin $display("FAIL prog_count: transfers=%0d required 4", xfer_count - base); miscompares++; end
    if (halted !== 1'b0) begin $display("FAIL prog_halted: got %b required 0", halted); miscompares++; end
  endtask

  task automatic test_illegal();
    logic [31:0] prog_a [4];
    logic [31:0] prog_b [4];
    logic [31:0] exp_pc [4];
    int          n;
    prog_a = '{32'h00000000, 32'h00100A13, 32'h100000B7, 32'h00000013};
    prog_b = '{32'h00000013, 32'h00000013, 32'h00209023, 32'h00001013};
    exp_pc = '{32'h0, 32'h0, 32'h4, 32'h4};
    for (int t = 0; t < 4; t++) begin
      clear_mem();
      mem[0] = prog_a[t];
      mem[1] = prog_b[t];
      fetch_delay = t % 2;
      apply_reset();
      n = 0;
      while (!halted && n < 50) begin
        @(negedge clk);
        n++;
      end
      repeat (5) @(negedge clk);
      vectors += 5;
      if (halted !== 1'b1) begin $display("FAIL ill%0d_halted: got %b required 1", t, halted); miscompares++; end
      if (illegal !== 1'b1) begin $display("FAIL ill%0d_flag: got %b required 1", t, illegal); miscompares++; end
      if (imem_req !== 1'b0) begin $display("FAIL ill%0d_req: got %b required 0", t, imem_req); miscompares++; end
      if (io_valid !== 1'b0) begin $display("FAIL ill%0d_io_valid: got %b required 0", t, io_valid); miscompares++; end
      if (imem_addr !== exp_pc[t]) begin $display("FAIL ill%0d_pc: got %h required %h", t, imem_addr, exp_pc[t]); miscompares++; end
    end
  endtask

  task automatic test_reset_iowait();
    int base;
    int n;
    load_uart_prog();
    fetch_delay = 0;
    ready_hold  = 1000;
    exp_q.delete();
    base = xfer_count;
    apply_reset();
    n = 0;
    while (!io_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (io_valid !== 1'b1) begin $display("FAIL iow_pending: io_valid=%b required 1", io_valid); miscompares++; end
    rst_n = 1'b0;
    #1;
    vectors += 3;
    if (io_valid !== 1'b0) begin $display("FAIL iow_rst_valid: got %b required 0", io_valid); miscompares++; end
    if (imem_addr !== 32'h0) begin $display("FAIL iow_rst_pc: got %h required 0", imem_addr); miscompares++; end
    if (imem_req !== 1'b0) begin $display("FAIL iow_rst_req: got %b required 0", imem_req); miscompares++; end
    @(negedge clk);
    ready_hold = 0;
    exp_q.push_back(8'h41);
    rst_n = 1'b1;
    vectors++;
    if (xfer_count !== base) begin $display("FAIL iow_no_xfer: transfers=%0d required 0", xfer_count - base); miscompares++; end
    wait_xfers(base + 1, 200, "iow_recover");
  endtask

  task automatic test_budget();
    int          n;
    logic [31:0] cc;
    b_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    b_rst_n = 1'b1;
    n = 0;
    while (!b_halted && n < 100) begin
      @(negedge clk);
      n++;
      if (!b_halted) begin
        vectors++;
        if (b_imem_addr !== 32'h0) begin $display("FAIL bud_pc: got %h required 0", b_imem_addr); miscompares++; end
      end
    end
    vectors += 5;
    if (b_halted !== 1'b1) begin $display("FAIL bud_halted: got %b required 1", b_halted); miscompares++; end
    if (b_illegal !== 1'b0) begin $display("FAIL bud_illegal: got %b required 0", b_illegal); miscompares++; end
    if (b_cycle_count < 32'd20 || b_cycle_count > 32'd24) begin
      $display("FAIL bud_count: got %0d required 20..24", b_cycle_count); miscompares++;
    end
    if (b_imem_req !== 1'b0) begin $display("FAIL bud_req: got %b required 0", b_imem_req); miscompares++; end
    if (b_imem_addr !== 32'h0) begin $display("FAIL bud_final_pc: got %h required 0", b_imem_addr); miscompares++; end
    cc = b_cycle_count;
    repeat (5) @(negedge clk);
    vectors += 2;
    if (b_cycle_count !== cc + 32'd5) begin $display("FAIL bud_count_runs: got %0d required %0d", b_cycle_count, cc + 32'd5); miscompares++; end
    if (b_halted !== 1'b1) begin $display("FAIL bud_stays: got %b required 1", b_halted); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_uart(0, 0, "uart_rdy");
    test_uart(5, 0, "uart_hold5");
    test_uart(0, 3, "uart_lat3");
    test_uart(2, 3, "uart_hold2_lat3");
    test_program();
    test_illegal();
    test_reset_iowait();
    test_budget();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
